// File: rtl/fadd_n36_norm_round.sv
// Normalize / round-to-nearest-even / exponent-saturate stage for the 36-bit
// fraction FP adder. Stage 1 normalizes, stage 2 rounds and packs.
module fadd_n36_norm_round #(
  parameter int FRAC_WIDTH = 36,
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 24
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic                        i_sign,
  input  logic signed [EXP_WIDTH-1:0] i_exp,
  input  logic [FRAC_WIDTH-1:0]       i_frac,
  input  logic                        i_flush,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic                        o_sign,
  output logic signed [EXP_WIDTH-1:0] o_exp,
  output logic [MANT_WIDTH-1:0]       o_mant,
  output logic                        o_zero,
  output logic                        o_ovf,
  output logic                        o_unf
);

  localparam int LZC_WIDTH = $clog2(FRAC_WIDTH + 1);
  localparam int EW        = EXP_WIDTH + 2;
  localparam int RND_LSB   = FRAC_WIDTH - MANT_WIDTH;

  localparam logic signed [EW-1:0] EXP_MAX = EW'(2 ** (EXP_WIDTH - 1) - 1);
  localparam logic signed [EW-1:0] EXP_MIN = EW'(-(2 ** (EXP_WIDTH - 1)));

  localparam logic [EXP_WIDTH-1:0]  EXP_SAT_HI = {1'b0, {(EXP_WIDTH-1){1'b1}}};
  localparam logic [EXP_WIDTH-1:0]  EXP_SAT_LO = {1'b1, {(EXP_WIDTH-1){1'b0}}};
  localparam logic [MANT_WIDTH-1:0] MANT_ONE   = {1'b1, {(MANT_WIDTH-1){1'b0}}};

  // Pipeline control
  logic s1_valid;
  logic s2_load;
  logic s1_adv;
  logic in_fire;

  assign s2_load = ~o_valid | i_ready;
  assign s1_adv  = ~s1_valid | s2_load;
  assign o_ready = s1_adv;
  assign in_fire = i_valid & o_ready;

  // Stage 1: leading-zero count and normalize
  logic [LZC_WIDTH-1:0]  lzc;
  logic [FRAC_WIDTH-1:0] norm;
  logic                  zero1;
  logic [EW-1:0]         exp_ext;
  logic [EW-1:0]         lzc_ext;
  logic [EW-1:0]         e1;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    lzc = LZC_WIDTH'(FRAC_WIDTH);
    // Scanning upward lets the highest set bit have the last word.
    for (int i = 0; i < FRAC_WIDTH; i++) begin
      if (i_frac[i]) lzc = LZC_WIDTH'(FRAC_WIDTH - 1 - i);
    end
  end

  assign zero1   = (i_frac == '0);
  assign norm    = i_frac << lzc;
  assign exp_ext = {{(EW-EXP_WIDTH){i_exp[EXP_WIDTH-1]}}, i_exp};
  assign lzc_ext = {{(EW-LZC_WIDTH){1'b0}}, lzc};
  assign e1      = zero1 ? '0 : (exp_ext - lzc_ext);

  logic                  s1_sign;
  logic                  s1_zero;
  logic [FRAC_WIDTH-1:0] s1_norm;
  logic signed [EW-1:0]  s1_exp;

  // Stage 2: round to nearest-even, then saturate
  logic [MANT_WIDTH-1:0] mant_trunc;
  logic                  guard;
  logic                  sticky;
  logic                  round_up;
  logic [MANT_WIDTH:0]   mant_sum;
  logic                  carry;
  logic [MANT_WIDTH-1:0] mant_rnd;
  logic signed [EW-1:0]  e2;

  assign mant_trunc = s1_norm[FRAC_WIDTH-1 -: MANT_WIDTH];
  assign guard      = s1_norm[RND_LSB-1];
  assign sticky     = |s1_norm[RND_LSB-2:0];
  assign round_up   = guard & (sticky | mant_trunc[0]);
  assign mant_sum   = {1'b0, mant_trunc} + {{MANT_WIDTH{1'b0}}, round_up};
  assign carry      = mant_sum[MANT_WIDTH];
  assign mant_rnd   = carry ? MANT_ONE : mant_sum[MANT_WIDTH-1:0];
  assign e2         = s1_exp + {{(EW-1){1'b0}}, carry};

  logic [EXP_WIDTH-1:0]  nx_exp;
  logic [MANT_WIDTH-1:0] nx_mant;
  logic                  nx_zero;
  logic                  nx_ovf;
  logic                  nx_unf;

  always_comb begin
    nx_exp  = e2[EXP_WIDTH-1:0];
    nx_mant = mant_rnd;
    nx_zero = 1'b0;
    nx_ovf  = 1'b0;
    nx_unf  = 1'b0;
    if (s1_zero) begin
      nx_exp  = '0;
      nx_mant = '0;
      nx_zero = 1'b1;
    end else if (e2 > EXP_MAX) begin
      nx_exp  = EXP_SAT_HI;
      nx_mant = '1;
      nx_ovf  = 1'b1;
    end else if (e2 < EXP_MIN) begin
      nx_exp  = EXP_SAT_LO;
      nx_mant = '0;
      nx_zero = 1'b1;
      nx_unf  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_norm  <= '0;
      s1_exp   <= '0;
      o_valid  <= 1'b0;
      o_sign   <= 1'b0;
      o_exp    <= '0;
      o_mant   <= '0;
      o_zero   <= 1'b0;
      o_ovf    <= 1'b0;
      o_unf    <= 1'b0;
    end else if (i_flush) begin
      s1_valid <= 1'b0;
      o_valid  <= 1'b0;
    end else begin
      if (s2_load) begin
        o_valid <= s1_valid;
        if (s1_valid) begin
          o_sign <= s1_sign;
          o_exp  <= nx_exp;
          o_mant <= nx_mant;
          o_zero <= nx_zero;
          o_ovf  <= nx_ovf;
          o_unf  <= nx_unf;
        end
      end
      if (s1_adv) begin
        s1_valid <= i_valid;
      end
      // Stage-1 data only moves on a real input transfer.
      if (in_fire) begin
        s1_sign <= i_sign;
        s1_zero <= zero1;
        s1_norm <= norm;
        s1_exp  <= e1;
      end
    end
  end

endmodule

// File: tb/tb_fadd_n36_norm_round.sv
// Directed self-checking bench for fadd_n36_norm_round: normalization,
// round-to-nearest-even, saturation, backpressure, flush and async reset.
module tb_fadd_n36_norm_round;

  logic              i_clk   = 1'b0;
  logic              i_rst   = 1'b0;
  logic              i_valid = 1'b0;
  logic              i_sign  = 1'b0;
  logic signed [7:0] i_exp   = '0;
  logic [35:0]       i_frac  = '0;
  logic              i_flush = 1'b0;
  logic              i_ready = 1'b1;
  logic              o_ready;
  logic              o_valid;
  logic              o_sign;
  logic signed [7:0] o_exp;
  logic [23:0]       o_mant;
  logic              o_zero;
  logic              o_ovf;
  logic              o_unf;

  int checks = 0;
  int errors = 0;

  fadd_n36_norm_round dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_sign (i_sign),
    .i_exp  (i_exp),
    .i_frac (i_frac),
    .i_flush(i_flush),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_sign (o_sign),
    .o_exp  (o_exp),
    .o_mant (o_mant),
    .o_zero (o_zero),
    .o_ovf  (o_ovf),
    .o_unf  (o_unf)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic expv);
    check(tag, {35'b0, obs}, {35'b0, expv});
  endtask

  task automatic check_out(input string tag, input logic s, input logic [7:0] e,
                           input logic [23:0] m, input logic z, input logic ov,
                           input logic un);
    check1({tag, ".valid"}, o_valid, 1'b1);
    check1({tag, ".sign"}, o_sign, s);
    check({tag, ".exp"}, {28'b0, o_exp}, {28'b0, e});
    check({tag, ".mant"}, {12'b0, o_mant}, {12'b0, m});
    check1({tag, ".zero"}, o_zero, z);
    check1({tag, ".ovf"}, o_ovf, ov);
    check1({tag, ".unf"}, o_unf, un);
  endtask

  task automatic cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic signed [7:0] e, input logic [35:0] f);
    i_sign  = s;
    i_exp   = e;
    i_frac  = f;
    i_valid = 1'b1;
  endtask

  // Offer one input, confirm it is taken, and land two edges later.
  task automatic one(input string tag, input logic s, input logic signed [7:0] e,
                     input logic [35:0] f);
    drive(s, e, f);
    check1({tag, ".in_ready"}, o_ready, 1'b1);
    cycle();
    i_valid = 1'b0;
    check1({tag, ".lat1"}, o_valid, 1'b0);
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1 i_rst = 1'b1;
    #3;
    check1("rst.valid", o_valid, 1'b0);
    check1("rst.ready", o_ready, 1'b1);
    check("rst.mant", {12'b0, o_mant}, 36'd0);
    check("rst.exp", {28'b0, o_exp}, 36'd0);
    check1("rst.sign", o_sign, 1'b0);
    check1("rst.zero", o_zero, 1'b0);
    check1("rst.ovf", o_ovf, 1'b0);
    check1("rst.unf", o_unf, 1'b0);
    @(posedge i_clk);
    #2 i_rst = 1'b0;
    cycle();

    // Normalization and zero
    one("norm0", 1'b0, 8'sd0, 36'h800000000);
    check_out("norm0", 1'b0, 8'h00, 24'h800000, 1'b0, 1'b0, 1'b0);
    one("lzc35", 1'b0, 8'sd10, 36'h000000001);
    check_out("lzc35", 1'b0, 8'hE7, 24'h800000, 1'b0, 1'b0, 1'b0);
    one("zero", 1'b1, 8'sd5, 36'h000000000);
    check_out("zero", 1'b1, 8'h00, 24'h000000, 1'b1, 1'b0, 1'b0);
    // lzc 11, then a tie that rounds up to even
    one("lzc11", 1'b0, 8'sd0, 36'h001234567);
    check_out("lzc11", 1'b0, 8'hF5, 24'h91A2B4, 1'b0, 1'b0, 1'b0);

    // Round to nearest-even
    one("tie_even", 1'b0, 8'sd3, 36'h800000800);
    check_out("tie_even", 1'b0, 8'h03, 24'h800000, 1'b0, 1'b0, 1'b0);
    one("tie_odd", 1'b0, 8'sd3, 36'h800001800);
    check_out("tie_odd", 1'b0, 8'h03, 24'h800002, 1'b0, 1'b0, 1'b0);
    one("above_half", 1'b0, 8'sd3, 36'h800000801);
    check_out("above_half", 1'b0, 8'h03, 24'h800001, 1'b0, 1'b0, 1'b0);

    // Carry out and saturation
    one("carry", 1'b0, 8'sd5, 36'hFFFFFF800);
    check_out("carry", 1'b0, 8'h06, 24'h800000, 1'b0, 1'b0, 1'b0);
    one("ovf", 1'b1, 8'sd127, 36'hFFFFFF800);
    check_out("ovf", 1'b1, 8'h7F, 24'hFFFFFF, 1'b0, 1'b1, 1'b0);
    one("unf", 1'b0, -8'sd100, 36'h000000001);
    check_out("unf", 1'b0, 8'h80, 24'h000000, 1'b1, 1'b0, 1'b1);
    cycle();
    check1("drain.valid", o_valid, 1'b0);

    // Backpressure: only two inputs fit while the output is stalled
    i_ready = 1'b0;
    drive(1'b0, 8'sd1, {24'hA00001, 12'h000});
    check1("bp.ready_a", o_ready, 1'b1);
    cycle();
    drive(1'b0, 8'sd2, {24'hA00002, 12'h000});
    check1("bp.ready_b", o_ready, 1'b1);
    cycle();
    drive(1'b0, 8'sd3, {24'hA00003, 12'h000});
    check1("bp.full_ready", o_ready, 1'b0);
    cycle();
    check1("bp.full_ready2", o_ready, 1'b0);
    check_out("bp.hold1", 1'b0, 8'h01, 24'hA00001, 1'b0, 1'b0, 1'b0);
    cycle();
    check_out("bp.hold2", 1'b0, 8'h01, 24'hA00001, 1'b0, 1'b0, 1'b0);
    i_ready = 1'b1;
    #1;
    check1("bp.release_ready", o_ready, 1'b1);
    cycle();
    check_out("bp.out_b", 1'b0, 8'h02, 24'hA00002, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'sd4, {24'hA00004, 12'h000});
    check1("bp.ready_d", o_ready, 1'b1);
    cycle();
    i_valid = 1'b0;
    check_out("bp.out_c", 1'b0, 8'h03, 24'hA00003, 1'b0, 1'b0, 1'b0);
    cycle();
    check_out("bp.out_d", 1'b0, 8'h04, 24'hA00004, 1'b0, 1'b0, 1'b0);
    cycle();
    check1("bp.empty", o_valid, 1'b0);

    // Flush with two results in flight and a third offered
    i_ready = 1'b0;
    drive(1'b0, 8'sd1, {24'hB00001, 12'h000});
    cycle();
    drive(1'b0, 8'sd2, {24'hB00002, 12'h000});
    cycle();
    check1("flush.pre_valid", o_valid, 1'b1);
    drive(1'b0, 8'sd3, {24'hB00003, 12'h000});
    i_flush = 1'b1;
    i_ready = 1'b1;
    cycle();
    i_flush = 1'b0;
    i_valid = 1'b0;
    check1("flush.valid", o_valid, 1'b0);
    check1("flush.ready", o_ready, 1'b1);
    cycle();
    check1("flush.no_ghost1", o_valid, 1'b0);
    cycle();
    check1("flush.no_ghost2", o_valid, 1'b0);

    // Asynchronous reset mid-stream
    drive(1'b0, 8'sd1, {24'hC00001, 12'h000});
    cycle();
    drive(1'b0, 8'sd2, {24'hC00002, 12'h000});
    cycle();
    i_valid = 1'b0;
    check_out("rst_mid.pre", 1'b0, 8'h01, 24'hC00001, 1'b0, 1'b0, 1'b0);
    #3 i_rst = 1'b1;
    #1;
    check1("rst_mid.valid", o_valid, 1'b0);
    check("rst_mid.mant", {12'b0, o_mant}, 36'd0);
    check1("rst_mid.ready", o_ready, 1'b1);
    #1 i_rst = 1'b0;
    cycle();
    check1("rst_mid.lost", o_valid, 1'b0);
    drive(1'b1, -8'sd7, {24'hC00003, 12'h000});
    check1("rst_mid.in_ready", o_ready, 1'b1);
    cycle();
    i_valid = 1'b0;
    check1("rst_mid.lat1", o_valid, 1'b0);
    cycle();
    check_out("rst_mid.new", 1'b1, 8'hF9, 24'hC00003, 1'b0, 1'b0, 1'b0);
    cycle();
    check1("rst_mid.end", o_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
